// File: rtl/jt900h_opq_pkg.sv
// Shared definitions for the TLCS-900H prefetch queue: bus FSM states,
// opcode window width and bus byte-order helpers.
package jt900h_opq_pkg;

    typedef enum logic {
        OPQ_IDLE = 1'b0,
        OPQ_BUS  = 1'b1
    } opq_state_t;

    localparam int OPW = 4;

    // Byte of a 16-bit bus word at the given address parity
    function automatic logic [7:0] word_byte(input logic [15:0] w, input logic odd);
        return odd ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/jt900h_opq_buf.sv
// Circular byte buffer for the prefetch queue: 0/1/2-byte push at the tail,
// 0-3-byte pop at the head and a zero-masked 4-byte read window.
module jt900h_opq_buf
    import jt900h_opq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          flush,
    input  logic [1:0]    push_n,
    input  logic [7:0]    push_b0,
    input  logic [7:0]    push_b1,
    input  logic [1:0]    pop_n,
    output logic [CW-1:0] cnt,
    output logic [31:0]   win
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] head, tail;

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (cen) begin
            if (flush) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                head <= head + PW'(pop_n);
                tail <= tail + PW'(push_n);
                cnt  <= cnt + CW'(push_n) - CW'(pop_n);
            end
        end
    end

    // NOTE: storage has no reset; every byte at or beyond cnt is masked in the window.
    always_ff @(posedge clk) begin
        if (cen && !flush) begin
            if (push_n != 2'd0) mem[tail] <= push_b0;
            if (push_n == 2'd2) mem[tail + PW'(1)] <= push_b1;
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < OPW; i++) begin
            if (CW'(i) < cnt) win[8*i +: 8] = mem[head + PW'(i)];
        end
    end

endmodule

// File: rtl/jt900h_opq.sv
// TLCS-900H instruction prefetch queue: bus FSM, pc/bus_addr counters and flush.
// Define JT900H_OPQ_PREFETCH_EN to fill up to DEPTH bytes instead of stopping at 4.
module jt900h_opq
    import jt900h_opq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 24
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_din,
    input  logic [1:0]    fetched,
    output logic [31:0]   op,
    output logic          op_ok,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] bus_addr,
    output logic          bus_rd,
    input  logic [15:0]   bus_din,
    input  logic          bus_ok
);

    localparam int CW = $clog2(DEPTH) + 1;
`ifdef JT900H_OPQ_PREFETCH_EN
    localparam int FILL_LIM = DEPTH;
`else
    localparam int FILL_LIM = OPW;
`endif

    opq_state_t    st, st_nx;
    logic [CW-1:0] cnt, cnt_pop, cnt_nx;
    logic [1:0]    pop_n, push_n;
    logic [AW-1:0] addr_nx;
    logic          accept;

    // A word fits when under the fill limit and the bytes it brings fit in the buffer
    function automatic logic has_room(input logic [CW-1:0] c, input logic odd);
        return (int'(c) < FILL_LIM) && (int'(c) + (odd ? 1 : 2) <= DEPTH);
    endfunction

    assign op_ok   = (cnt >= CW'(OPW));
    assign bus_rd  = (st == OPQ_BUS);
    assign pop_n   = (op_ok && !pc_load) ? fetched : 2'd0;
    assign accept  = (st == OPQ_BUS) && bus_ok && !pc_load;
    // An odd address only brings its upper byte; push size is also the address step
    assign push_n  = accept ? (bus_addr[0] ? 2'd1 : 2'd2) : 2'd0;
    assign cnt_pop = cnt - CW'(pop_n);
    assign cnt_nx  = cnt_pop + CW'(push_n);
    assign addr_nx = bus_addr + AW'(push_n);

    always_comb begin
        // NOTE: default first so no latch is inferred on paths that leave it alone.
        st_nx = st;
        case (st)
            OPQ_IDLE: if (has_room(cnt_pop, bus_addr[0])) st_nx = OPQ_BUS;
            OPQ_BUS:  if (bus_ok) st_nx = has_room(cnt_nx, addr_nx[0]) ? OPQ_BUS : OPQ_IDLE;
            default:  st_nx = OPQ_IDLE;
        endcase
        if (pc_load) st_nx = OPQ_IDLE;
    end

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            st       <= OPQ_IDLE;
            pc       <= '0;
            bus_addr <= '0;
        end else if (cen) begin
            st <= st_nx;
            if (pc_load) begin
                pc       <= pc_din;
                bus_addr <= pc_din;
            end else begin
                pc       <= pc + AW'(pop_n);
                bus_addr <= addr_nx;
            end
        end
    end

    jt900h_opq_buf #(.DEPTH(DEPTH), .CW(CW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .flush   (pc_load),
        .push_n  (push_n),
        .push_b0 (word_byte(bus_din, bus_addr[0])),
        .push_b1 (bus_din[15:8]),
        .pop_n   (pop_n),
        .cnt     (cnt),
        .win     (op)
    );

endmodule

// File: tb/tb_jt900h_opq.sv
// Self-checking bench for jt900h_opq: directed vector table, saturation runs
// and random traffic checked against a byte-queue reference model.
module tb_jt900h_opq;

    localparam int DEPTH = 8;
    localparam int AW    = 24;
`ifdef JT900H_OPQ_PREFETCH_EN
    localparam bit PF   = 1'b1;
    localparam int QMAX = DEPTH;
`else
    localparam bit PF   = 1'b0;
    localparam int QMAX = 5;
`endif

    logic          clk, rst, cen, pc_load, bus_rd, bus_ok, op_ok;
    logic [AW-1:0] pc_din, pc, bus_addr;
    logic [1:0]    fetched;
    logic [31:0]   op;
    logic [15:0]   bus_din;

    int total = 0;
    int bad   = 0;

    // Reference model: queued bytes, program counter and next fetch address
    logic [7:0]    q [$];
    logic [AW-1:0] mpc, maddr;

    typedef struct {
        logic        c;
        logic        ld;
        logic [23:0] din;
        logic [1:0]  f;
        logic        ok;
        logic [15:0] d;
        logic [31:0] e_op;
        logic        e_rd;
        logic [23:0] e_addr;
        logic [23:0] e_pc;
    } vec_t;

    vec_t tv [$];

    jt900h_opq #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .pc_load  (pc_load),
        .pc_din   (pc_din),
        .fetched  (fetched),
        .op       (op),
        .op_ok    (op_ok),
        .pc       (pc),
        .bus_addr (bus_addr),
        .bus_rd   (bus_rd),
        .bus_din  (bus_din),
        .bus_ok   (bus_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mwin();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) if (i < q.size()) w[8*i +: 8] = q[i];
        return w;
    endfunction

    // Called at a negedge: drive inputs, clock once, advance the model, compare.
    task automatic step(input logic c, input logic ld, input logic [23:0] din,
                        input logic [1:0] f, input logic ok, input logic [15:0] d);
        logic rd_pre;
        cen = c; pc_load = ld; pc_din = din; fetched = f; bus_ok = ok; bus_din = d;
        rd_pre = bus_rd;
        @(posedge clk);
        if (c) begin
            if (ld) begin
                q.delete();
                mpc   = din;
                maddr = din;
            end else begin
                if (f != 2'd0 && q.size() >= 4) begin
                    for (int i = 0; i < int'(f); i++) void'(q.pop_front());
                    mpc = mpc + 24'(f);
                end
                if (rd_pre && ok) begin
                    if (maddr[0]) q.push_back(d[15:8]);
                    else begin
                        q.push_back(d[7:0]);
                        q.push_back(d[15:8]);
                    end
                    maddr = maddr + (maddr[0] ? 24'd1 : 24'd2);
                end
            end
        end
        @(negedge clk);
        check("op", op, mwin());
        check("op_ok", 32'(op_ok), 32'(q.size() >= 4));
        check("pc", 32'(pc), 32'(mpc));
        check("bus_addr", 32'(bus_addr), 32'(maddr));
        check("overflow", 32'(q.size() <= QMAX), 32'd1);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; pc_load = 1'b0; pc_din = '0;
        fetched = '0; bus_ok = 1'b0; bus_din = '0;
        q.delete(); mpc = '0; maddr = '0;

        #12;
        check("rst_op", op, 32'h0);
        check("rst_op_ok", 32'(op_ok), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_rd", 32'(bus_rd), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Even start, pop with concurrent push, ignored pop while op_ok=0
        tv.push_back('{1, 1, 24'h1000, 0, 0, 16'h0000, 32'h0, 0, 24'h1000, 24'h1000});
        tv.push_back('{1, 0, 24'h0, 0, 0, 16'h0000, 32'h0, 1, 24'h1000, 24'h1000});
        tv.push_back('{1, 0, 24'h0, 0, 1, 16'h3412, 32'h00003412, 1, 24'h1002, 24'h1000});
        tv.push_back('{1, 0, 24'h0, 0, 1, 16'h7856, 32'h78563412, PF, 24'h1004, 24'h1000});
        tv.push_back('{1, 0, 24'h0, 3, PF, 16'hBA9A, PF ? 32'h00BA9A78 : 32'h00000078, 1,
                       PF ? 24'h1006 : 24'h1004, 24'h1003});
        tv.push_back('{1, 0, 24'h0, 2, 0, 16'h0000, PF ? 32'h00BA9A78 : 32'h00000078, 1,
                       PF ? 24'h1006 : 24'h1004, 24'h1003});
        // Odd start
        tv.push_back('{1, 1, 24'h2001, 0, 0, 16'h0000, 32'h0, 0, 24'h2001, 24'h2001});
        tv.push_back('{1, 0, 24'h0, 0, 0, 16'h0000, 32'h0, 1, 24'h2001, 24'h2001});
        tv.push_back('{1, 0, 24'h0, 0, 1, 16'hAB00, 32'h000000AB, 1, 24'h2002, 24'h2001});
        tv.push_back('{1, 0, 24'h0, 0, 1, 16'hDDCC, 32'h00DDCCAB, 1, 24'h2004, 24'h2001});
        tv.push_back('{1, 0, 24'h0, 0, 1, 16'hFFEE, 32'hEEDDCCAB, PF, 24'h2006, 24'h2001});
        // Flush colliding with bus_ok and fetched
        tv.push_back('{1, 0, 24'h0, 2, 0, 16'h0000, 32'h00FFEEDD, 1, 24'h2006, 24'h2003});
        tv.push_back('{1, 1, 24'h3000, 1, 1, 16'h1111, 32'h0, 0, 24'h3000, 24'h3000});
        tv.push_back('{1, 0, 24'h0, 0, 0, 16'h0000, 32'h0, 1, 24'h3000, 24'h3000});
        tv.push_back('{1, 0, 24'h0, 0, 1, 16'h2222, 32'h00002222, 1, 24'h3002, 24'h3000});
        // Bus stall with cen toggling; bus_ok with cen=0 is ignored
        for (int i = 0; i < 5; i++)
            tv.push_back('{(i % 2) == 1, 0, 24'h0, 0, 0, 16'h0000, 32'h00002222, 1, 24'h3002, 24'h3000});
        tv.push_back('{0, 0, 24'h0, 0, 1, 16'h4444, 32'h00002222, 1, 24'h3002, 24'h3000});
        tv.push_back('{1, 0, 24'h0, 0, 1, 16'h4444, 32'h44442222, PF, 24'h3004, 24'h3000});

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].c, tv[i].ld, tv[i].din, tv[i].f, tv[i].ok, tv[i].d);
            check($sformatf("tv%0d_op", i), op, tv[i].e_op);
            check($sformatf("tv%0d_rd", i), 32'(bus_rd), 32'(tv[i].e_rd));
            check($sformatf("tv%0d_addr", i), 32'(bus_addr), 32'(tv[i].e_addr));
            check($sformatf("tv%0d_pc", i), 32'(pc), 32'(tv[i].e_pc));
        end

        // Fill with no consumption, even then odd start
        step(1, 1, 24'h4000, 0, 0, 16'h0);
        for (int i = 0; i < 30; i++) step(1, 0, 24'h0, 0, 1, 16'($urandom));
        check("sat_even_cnt", 32'(q.size()), PF ? 32'(DEPTH) : 32'd4);
        check("sat_even_rd", 32'(bus_rd), 32'd0);
        step(1, 1, 24'h5001, 0, 0, 16'h0);
        for (int i = 0; i < 30; i++) step(1, 0, 24'h0, 0, 1, 16'($urandom));
        check("sat_odd_cnt", 32'(q.size()), PF ? 32'(DEPTH - 1) : 32'd5);
        check("sat_odd_rd", 32'(bus_rd), 32'd0);

        // Random traffic, including address wrap near the top of memory
        for (int i = 0; i < 3000; i++) begin
            logic        c, ld, ok;
            logic [23:0] din;
            c   = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 99) == 0);
            din = ($urandom_range(0, 3) == 0) ? (24'hFFFFFF - 24'($urandom_range(0, 5)))
                                              : 24'($urandom);
            ok  = ($urandom_range(0, 2) != 0);
            step(c, ld, din, 2'($urandom_range(0, 3)), ok, 16'($urandom));
        end

        // Reset in the middle of a pending read
        step(1, 1, 24'h6000, 0, 0, 16'h0);
        for (int i = 0; i < 10 && !bus_rd; i++) step(1, 0, 24'h0, 0, 0, 16'h0);
        check("rd_wait", 32'(bus_rd), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_rd", 32'(bus_rd), 32'd0);
        check("rst_mid_addr", 32'(bus_addr), 32'd0);
        check("rst_mid_op_ok", 32'(op_ok), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
